// File: rtl/sobel_loader_pkg.sv
// sobel_loader_pkg: scan states and shared constants for the Sobel loader
package sobel_loader_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} scan_state_e;
  localparam int STALL_CNT_W = 16;
  localparam int WIN_OFFSET = 2;
endpackage

// File: rtl/sobel_scan_controller_if.sv
// sobel_scan_controller_if: control and read-port bundle of the scan controller
interface sobel_scan_controller_if import sobel_loader_pkg::*; #(parameter int NumOfBit = 8);
  logic Start;
  logic Stall;
  logic Rd_En;
  logic [2*NumOfBit-1:0] Rd_Addr;
  logic [NumOfBit-1:0] Out_Row;
  logic [NumOfBit-1:0] Out_Column;
  logic Window_Valid;
  logic [NumOfBit-1:0] Win_Row;
  logic [NumOfBit-1:0] Win_Column;
  logic Busy;
  logic Done;
  logic [STALL_CNT_W-1:0] Stall_Count;
  modport master (
    output Start, Stall,
    input Rd_En, Rd_Addr, Out_Row, Out_Column, Window_Valid, Win_Row, Win_Column, Busy, Done, Stall_Count
  );
  modport slave (
    input Start, Stall,
    output Rd_En, Rd_Addr, Out_Row, Out_Column, Window_Valid, Win_Row, Win_Column, Busy, Done, Stall_Count
  );
endinterface

// File: rtl/sobel_scan_controller_raster_counter.sv
// raster_counter: raster-order row/column counters that stop on the last pixel
module raster_counter #(
  parameter int NumOfBit = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic [NumOfBit-1:0] row,
  output logic [NumOfBit-1:0] column,
  output logic last
);
  logic col_end;
  assign col_end = column == NumOfBit'(IMG_W - 1);
  assign last = col_end & (row == NumOfBit'(IMG_H - 1));
  // advance column, wrapping into the next row; hold once the last pixel is read
  always_ff @(posedge clk) begin
    if (rst | clear) begin
      row <= '0;
      column <= '0;
    end else if (enable & ~last) begin
      column <= col_end ? '0 : column + 1'b1;
      row <= col_end ? row + 1'b1 : row;
    end
  end
endmodule

// File: rtl/sobel_scan_controller.sv
// sobel_scan_controller: Start/Done raster scan sequencer with 3x3 window flags; SOBEL_STALL_CNT_EN adds a stall counter
module sobel_scan_controller import sobel_loader_pkg::*; #(
  parameter int NumOfBit = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input logic CLK,
  input logic Reset,
  sobel_scan_controller_if.slave bus
);
  scan_state_e state, state_n;
  logic [NumOfBit-1:0] row, col;
  logic [2*NumOfBit-1:0] addr;
  logic last, accept, rd_en, win_hit;
  logic wv;
  logic [NumOfBit-1:0] wr, wc;
  raster_counter #(.NumOfBit(NumOfBit), .IMG_W(IMG_W), .IMG_H(IMG_H)) u_cnt (
    .clk(CLK),
    .rst(Reset),
    .clear(accept),
    .enable(rd_en),
    .row(row),
    .column(col),
    .last(last)
  );
  // state register
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else state <= state_n;
  end
  // next state and read strobe
  always_comb begin
    state_n = state;
    accept = state == IDLE & bus.Start;
    rd_en = state == SCAN & ~bus.Stall;
    case (state)
      IDLE:    state_n = bus.Start ? SCAN : IDLE;
      SCAN:    state_n = rd_en & last ? FLUSH : SCAN;
      FLUSH:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // linear address runs alongside the counters so no multiplier is needed
  always_ff @(posedge CLK) begin
    if (Reset | accept) addr <= '0;
    else if (rd_en & ~last) addr <= addr + 1'b1;
  end
  assign win_hit = rd_en & (row >= NumOfBit'(WIN_OFFSET)) & (col >= NumOfBit'(WIN_OFFSET));
  // window flag lines up with the read data returned one cycle later
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wv <= 1'b0;
      wr <= '0;
      wc <= '0;
    end else begin
      wv <= win_hit;
      if (win_hit) begin
        wr <= row - NumOfBit'(WIN_OFFSET - 1);
        wc <= col - NumOfBit'(WIN_OFFSET - 1);
      end
    end
  end
`ifdef SOBEL_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt;
  // saturating count of stalled scan cycles, kept until the next accepted Start
  always_ff @(posedge CLK) begin
    if (Reset | accept) stall_cnt <= '0;
    else if (state == SCAN & bus.Stall & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
  end
  assign bus.Stall_Count = stall_cnt;
`else
  assign bus.Stall_Count = '0;
`endif
  assign bus.Rd_En = rd_en;
  assign bus.Rd_Addr = addr;
  assign bus.Out_Row = row;
  assign bus.Out_Column = col;
  assign bus.Window_Valid = wv;
  assign bus.Win_Row = wr;
  assign bus.Win_Column = wc;
  assign bus.Busy = state == SCAN | state == FLUSH;
  assign bus.Done = state == DONE;
endmodule
